// File: rtl/itch_pkg.sv
// ITCH 5.0 shared definitions for the Add Order encode/decode path.
// Holds the message type and side codes, the body length, the byte offset
// of every field inside the 36-byte body, the encoder FSM state type and
// the packed field bundle that the encoder captures into its shadow register.
package itch_pkg;

    localparam logic [7:0] ITCH_ADD_ORDER_TYPE = 8'h41;
    localparam int         ADD_ORDER_LEN       = 36;
    localparam logic [7:0] ITCH_BUY            = 8'h42;
    localparam logic [7:0] ITCH_SELL           = 8'h53;

    // Byte offsets inside the message body (type byte is offset 0).
    localparam int OFF_TYPE   = 0;
    localparam int OFF_LOCATE = 1;
    localparam int OFF_TRACK  = 3;
    localparam int OFF_TS     = 5;
    localparam int OFF_REF    = 11;
    localparam int OFF_SIDE   = 19;
    localparam int OFF_SHARES = 20;
    localparam int OFF_STOCK  = 24;
    localparam int OFF_PRICE  = 32;

    // Big-endian length prefix value sent ahead of the body when enabled.
    localparam logic [15:0] PREFIX_WORD = 16'(ADD_ORDER_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [15:0] stock_locate;
        logic [15:0] tracking_number;
        logic [47:0] timestamp;
        logic [63:0] order_ref;
        logic        buy_sell;
        logic [31:0] shares;
        logic [63:0] stock_symbol;
        logic [31:0] price;
    } add_order_t;

endpackage

// File: rtl/itch_add_order_byte_mux.sv
// Combinational byte selector for an Add Order frame.
// Ports:
//   fields_i : captured field bundle
//   idx_i    : frame byte index (prefix bytes first when PREFIX_LEN=1)
//   byte_o   : byte at idx_i, 0 when idx_i is past the end of the frame
module itch_add_order_byte_mux
    import itch_pkg::*;
#(
    parameter int PREFIX_LEN = 1
) (
    input  add_order_t  fields_i,
    input  logic [5:0]  idx_i,
    output logic [7:0]  byte_o
);

    localparam logic [5:0] PREFIX_BYTES = 6'(2 * PREFIX_LEN);

    logic [7:0] body [ADD_ORDER_LEN];
    logic [5:0] body_idx;

    assign body[OFF_TYPE] = ITCH_ADD_ORDER_TYPE;
    assign body[OFF_SIDE] = fields_i.buy_sell ? ITCH_BUY : ITCH_SELL;

    // Every multi-byte field is laid out MSB byte first.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_locate
            assign body[OFF_LOCATE + gi] = fields_i.stock_locate[8*(1-gi) +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_track
            assign body[OFF_TRACK + gi] = fields_i.tracking_number[8*(1-gi) +: 8];
        end
        for (gi = 0; gi < 6; gi++) begin : g_ts
            assign body[OFF_TS + gi] = fields_i.timestamp[8*(5-gi) +: 8];
        end
        for (gi = 0; gi < 8; gi++) begin : g_ref
            assign body[OFF_REF + gi] = fields_i.order_ref[8*(7-gi) +: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_shares
            assign body[OFF_SHARES + gi] = fields_i.shares[8*(3-gi) +: 8];
        end
        for (gi = 0; gi < 8; gi++) begin : g_stock
            assign body[OFF_STOCK + gi] = fields_i.stock_symbol[8*(7-gi) +: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_price
            assign body[OFF_PRICE + gi] = fields_i.price[8*(3-gi) +: 8];
        end
    endgenerate

    assign body_idx = idx_i - PREFIX_BYTES;

    always_comb begin
        byte_o = 8'h00;
        if (idx_i < PREFIX_BYTES) begin
            byte_o = (idx_i == 6'd0) ? PREFIX_WORD[15:8] : PREFIX_WORD[7:0];
        end else if (body_idx < 6'(ADD_ORDER_LEN)) begin
            byte_o = body[body_idx];
        end
    end

endmodule

// File: rtl/add_order_encoder.sv
// ITCH 5.0 Add Order serializer: captures a parallel field bundle and
// streams it as a big-endian byte frame with byte-level backpressure.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : field bundle handshake (ready only in IDLE)
//   stock_locate .. price : Add Order fields
//   tcp_payload_out, tcp_byte_valid_out, out_ready : byte stream handshake
//   start_flag_out      : marks byte 0 of every frame
//   frame_done          : one-cycle pulse after the last byte is accepted
//   busy                : high while sending or in the inter-frame gap
module add_order_encoder
    import itch_pkg::*;
#(
    parameter int PREFIX_LEN = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] stock_locate,
    input  logic [15:0] tracking_number,
    input  logic [47:0] timestamp,
    input  logic [63:0] order_ref,
    input  logic        buy_sell,
    input  logic [31:0] shares,
    input  logic [63:0] stock_symbol,
    input  logic [31:0] price,
    output logic [7:0]  tcp_payload_out,
    output logic        tcp_byte_valid_out,
    input  logic        out_ready,
    output logic        start_flag_out,
    output logic        frame_done,
    output logic        busy
);

    localparam int         FRAME_LEN = ADD_ORDER_LEN + 2 * PREFIX_LEN;
    localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);
    // Loaded as GAP_CYCLES-1 so the GAP state lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    enc_state_e state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [3:0] gap_q, gap_d;
    add_order_t shadow_q, shadow_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic [7:0] mux_byte;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shadow_d.stock_locate    = stock_locate;
                    shadow_d.tracking_number = tracking_number;
                    shadow_d.timestamp       = timestamp;
                    shadow_d.order_ref       = order_ref;
                    shadow_d.buy_sell        = buy_sell;
                    shadow_d.shares          = shares;
                    shadow_d.stock_symbol    = stock_symbol;
                    shadow_d.price           = price;
                    state_d = ST_SEND;
                    idx_d   = 6'd0;
                    valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 6'd0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // The mux looks at next-state index and shadow so the outgoing byte is
    // a true register that holds still while out_ready is low.
    itch_add_order_byte_mux #(
        .PREFIX_LEN (PREFIX_LEN)
    ) u_byte_mux (
        .fields_i (shadow_d),
        .idx_i    (idx_d),
        .byte_o   (mux_byte)
    );

    assign data_d  = valid_d ? mux_byte : 8'h00;
    assign start_d = valid_d && (idx_d == 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 6'd0;
            gap_q    <= 4'd0;
            shadow_q <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign in_ready           = (state_q == ST_IDLE) && !rst;
    assign busy               = (state_q != ST_IDLE);
    assign tcp_payload_out    = data_q;
    assign tcp_byte_valid_out = valid_q;
    assign start_flag_out     = start_q;
    assign frame_done         = done_q;

endmodule

// File: tb/tb_add_order_encoder.sv
// Bench for add_order_encoder: directed frames, backpressure, busy rejection,
// back-to-back gap timing, mid-frame reset and a randomized run, all scored
// against a byte-list model of the Add Order frame.
module tb_add_order_encoder;

    localparam int PREFIX_LEN = 1;
    localparam int GAP_CYCLES = 2;
    localparam int FRAME_LEN  = 36 + 2 * PREFIX_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] stock_locate = '0;
    logic [15:0] tracking_number = '0;
    logic [47:0] timestamp = '0;
    logic [63:0] order_ref = '0;
    logic        buy_sell = 1'b0;
    logic [31:0] shares = '0;
    logic [63:0] stock_symbol = '0;
    logic [31:0] price = '0;
    logic [7:0]  tcp_payload_out;
    logic        tcp_byte_valid_out;
    logic        out_ready = 1'b1;
    logic        start_flag_out;
    logic        frame_done;
    logic        busy;

    add_order_encoder #(
        .PREFIX_LEN (PREFIX_LEN),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .stock_locate       (stock_locate),
        .tracking_number    (tracking_number),
        .timestamp          (timestamp),
        .order_ref          (order_ref),
        .buy_sell           (buy_sell),
        .shares             (shares),
        .stock_symbol       (stock_symbol),
        .price              (price),
        .tcp_payload_out    (tcp_payload_out),
        .tcp_byte_valid_out (tcp_byte_valid_out),
        .out_ready          (out_ready),
        .start_flag_out     (start_flag_out),
        .frame_done         (frame_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [7:0] exp_frame [FRAME_LEN];
    logic [7:0] obs_frame [FRAME_LEN];
    int  cyc = 0;
    int  mon_pos = 0;
    bit  sending = 0;
    int  idle_from = 0;
    int  cap_cyc = 0;
    int  last_acc_cyc = -100;
    int  last_gap = 0;
    bit  first_seen = 0;
    bit  done_exp = 0;
    int  frames = 0;

    // Build the expected byte list from the current input fields.
    task automatic build_frame();
        int n;
        n = 0;
        if (PREFIX_LEN != 0) begin
            exp_frame[n++] = 8'h00;
            exp_frame[n++] = 8'd36;
        end
        exp_frame[n++] = 8'h41;
        for (int b = 1; b >= 0; b--) exp_frame[n++] = 8'(stock_locate >> (8 * b));
        for (int b = 1; b >= 0; b--) exp_frame[n++] = 8'(tracking_number >> (8 * b));
        for (int b = 5; b >= 0; b--) exp_frame[n++] = 8'(timestamp >> (8 * b));
        for (int b = 7; b >= 0; b--) exp_frame[n++] = 8'(order_ref >> (8 * b));
        exp_frame[n++] = buy_sell ? 8'h42 : 8'h53;
        for (int b = 3; b >= 0; b--) exp_frame[n++] = 8'(shares >> (8 * b));
        for (int b = 7; b >= 0; b--) exp_frame[n++] = 8'(stock_symbol >> (8 * b));
        for (int b = 3; b >= 0; b--) exp_frame[n++] = 8'(price >> (8 * b));
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            bit exp_ready;
            bit exp_valid;
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_pos    = 0;
                sending    = 0;
                idle_from  = cyc + 1;
                done_exp   = 0;
                first_seen = 0;
            end else begin
                exp_ready = (cyc >= idle_from) && !sending;
                exp_valid = sending && (cyc > cap_cyc);
                check_eq("in_ready", in_ready, exp_ready);
                check_eq("busy", busy, !exp_ready);
                check_eq("frame_done", frame_done, done_exp);
                if (done_exp) frames++;
                done_exp = 0;
                check_eq("byte_valid", tcp_byte_valid_out, exp_valid);
                if (exp_valid && tcp_byte_valid_out) begin
                    check_eq($sformatf("byte%0d", mon_pos), tcp_payload_out, exp_frame[mon_pos]);
                    check_eq("start_flag", start_flag_out, mon_pos == 0);
                    if (mon_pos == 0 && !first_seen) begin
                        first_seen = 1;
                        last_gap   = cyc - last_acc_cyc;
                    end
                    if (out_ready) begin
                        obs_frame[mon_pos] = tcp_payload_out;
                        mon_pos++;
                        if (mon_pos == FRAME_LEN) begin
                            mon_pos      = 0;
                            sending      = 0;
                            done_exp     = 1;
                            idle_from    = cyc + 1 + GAP_CYCLES;
                            last_acc_cyc = cyc;
                        end
                    end
                end
                if (in_valid && exp_ready) begin
                    build_frame();
                    sending    = 1;
                    cap_cyc    = cyc;
                    first_seen = 0;
                end
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = stall at idx 5 and 37.
    int ready_mode = 0;
    bit st5 = 0;
    bit st37 = 0;
    int stall = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall > 0) begin
                        out_ready = 1'b0;
                        stall--;
                    end else if (sending && mon_pos == 5 && !st5) begin
                        st5 = 1; stall = 2; out_ready = 1'b0;
                    end else if (sending && mon_pos == 37 && !st37) begin
                        st37 = 1; stall = 2; out_ready = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_fields(input logic [15:0] loc, input logic [15:0] trk,
                              input logic [47:0] ts, input logic [63:0] oref,
                              input logic side, input logic [31:0] shr,
                              input logic [63:0] sym, input logic [31:0] prc);
        stock_locate = loc; tracking_number = trk; timestamp = ts; order_ref = oref;
        buy_sell = side; shares = shr; stock_symbol = sym; price = prc;
    endtask

    task automatic rand_fields();
        set_fields(16'($urandom), 16'($urandom), {16'($urandom), 32'($urandom)},
                   {32'($urandom), 32'($urandom)}, 1'($urandom), 32'($urandom),
                   {32'($urandom), 32'($urandom)}, 32'($urandom));
    endtask

    task automatic send_bundle();
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 0, 1);
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 20000 && frames < target; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("frame_count", frames, target);
    endtask

    task automatic check_golden(input string tag);
        logic [303:0] golden;
        golden = 304'h0024_4100_0100_0200_0012_3456_7801_0203_0405_0607_0842_0000_0064_4141_504C_2020_2020_0016_E360;
        for (int i = 0; i < FRAME_LEN; i++)
            check_eq($sformatf("%s_b%0d", tag, i), obs_frame[i], golden[303 - 8 * i -: 8]);
    endtask

    task automatic set_basic();
        set_fields(16'h0001, 16'h0002, 48'h0000_1234_5678, 64'h0102030405060708,
                   1'b1, 32'd100, 64'h4141504C20202020, 32'd1500000);
    endtask

    // Reset asserted right now; outputs are checked after the next edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_payload", tcp_payload_out, 0);
        check_eq("rst_valid", tcp_byte_valid_out, 0);
        check_eq("rst_start", start_flag_out, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int expected_frames;
        expected_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic frame with a golden byte list.
        set_basic();
        send_bundle();
        expected_frames++;
        wait_frames(expected_frames);
        check_golden("basic");

        // Backpressure at idx 5 and idx 37.
        ready_mode = 2; st5 = 0; st37 = 0;
        set_basic();
        send_bundle();
        expected_frames++;
        wait_frames(expected_frames);
        check_eq("stall5_hit", st5, 1);
        check_eq("stall37_hit", st37, 1);
        check_golden("bp");
        ready_mode = 0;

        // Busy rejection: pulse different fields while sending.
        set_basic();
        send_bundle();
        expected_frames++;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_frames(expected_frames);
        check_golden("busy_rej");

        // Back-to-back with in_valid held: sell then buy.
        rand_fields(); buy_sell = 1'b0;
        send_bundle();
        rand_fields();
        send_bundle();
        expected_frames += 2;
        wait_frames(expected_frames);
        // Last byte taken at edge E, next frame's byte 0 driven at edge E+3,
        // which shows up four falling edges after the accept sample.
        check_eq("b2b_gap", last_gap, GAP_CYCLES + 2);

        // Reset mid-frame at idx 20, then a fresh frame.
        rand_fields();
        send_bundle();
        for (int i = 0; i < 200 && mon_pos != 20; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("reach_idx20", mon_pos, 20);
        do_reset();
        set_basic();
        send_bundle();
        expected_frames++;
        wait_frames(expected_frames);
        check_golden("post_rst");

        // Randomized run with random out_ready.
        ready_mode = 1;
        for (int n = 0; n < 500; n++) begin
            rand_fields();
            send_bundle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        expected_frames += 500;
        wait_frames(expected_frames);
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
